// File: rtl/shift_sequencer.sv
// Multi-cycle 16-bit shift/rotate unit: ROL/SLL/ROR/SRA built from one
// rotate-left-by-2^k stage applied once per cycle, with a final edge mask.
module shift_sequencer #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [3:0]  in_cnt,
    input  logic [1:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ROT = 2'd1, OUT = 2'd2} state_t;

    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    state_t      state_q;
    logic [15:0] acc_q;
    logic [15:0] out_data_q;
    logic        out_valid_q;
    logic [3:0]  cnt_q;
    logic [3:0]  eff_q;
    logic [1:0]  op_q;
    logic [1:0]  k_q;
    logic        sign_q;

    logic [3:0]  eff_d;
    logic [15:0] rot_d;
    logic [15:0] stage_d;
    logic [15:0] result_d;
    logic [15:0] keep_d;
    logic [15:0] fill_d;
    logic [1:0]  msb_d;
    logic        last_d;

    // Right shifts are left rotates by (16 - cnt) mod 16, i.e. the 4-bit negation.
    always_comb begin
        eff_d = in_op[1] ? (4'd0 - in_cnt) : in_cnt;
    end

    always_comb begin
        rot_d = acc_q;
        case (k_q)
            2'd0: rot_d = {acc_q[14:0], acc_q[15]};
            2'd1: rot_d = {acc_q[13:0], acc_q[15:14]};
            2'd2: rot_d = {acc_q[11:0], acc_q[15:12]};
            2'd3: rot_d = {acc_q[7:0],  acc_q[15:8]};
            default: rot_d = acc_q;
        endcase
        stage_d = eff_q[k_q] ? rot_d : acc_q;
    end

    always_comb begin
        msb_d = 2'd0;
        if (eff_q[3])      msb_d = 2'd3;
        else if (eff_q[2]) msb_d = 2'd2;
        else if (eff_q[1]) msb_d = 2'd1;
        last_d = EARLY_EXIT ? (k_q == msb_d) : (k_q == 2'd3);
    end

    // keep_d clears the low cnt bits (SLL); fill_d marks the high cnt bits (SRA).
    always_comb begin
        keep_d   = 16'hFFFF << cnt_q;
        fill_d   = ~(16'hFFFF >> cnt_q);
        result_d = stage_d;
        if (op_q == OP_SLL)
            result_d = stage_d & keep_d;
        else if (op_q == OP_SRA)
            result_d = sign_q ? (stage_d | fill_d) : (stage_d & ~fill_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= 16'h0000;
            out_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
            cnt_q       <= 4'd0;
            eff_q       <= 4'd0;
            op_q        <= 2'd0;
            k_q         <= 2'd0;
            sign_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q   <= in_data;
                        op_q    <= in_op;
                        cnt_q   <= in_cnt;
                        eff_q   <= eff_d;
                        sign_q  <= in_data[15];
                        k_q     <= 2'd0;
                        state_q <= ROT;
                    end
                end
                ROT: begin
                    acc_q <= stage_d;
                    if (last_d) begin
                        out_data_q  <= result_d;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: one EARLY_EXIT=1 and one EARLY_EXIT=0 instance, checked
// against an arithmetic shift/rotate model with directed and random requests.
module tb_shift_sequencer;
    logic              clk;
    logic              rst_n;
    logic [1:0]        in_valid;
    logic [1:0]        in_ready;
    logic [1:0][15:0]  in_data;
    logic [1:0][3:0]   in_cnt;
    logic [1:0][1:0]   in_op;
    logic [1:0]        out_valid;
    logic [1:0]        out_ready;
    logic [1:0][15:0]  out_data;
    logic [1:0]        busy;

    int nchk = 0;
    int nerr = 0;

    shift_sequencer #(.EARLY_EXIT(1'b1)) dut_ee1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_cnt(in_cnt[0]), .in_op(in_op[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0])
    );

    shift_sequencer #(.EARLY_EXIT(1'b0)) dut_ee0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_cnt(in_cnt[1]), .in_op(in_op[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain shift/rotate arithmetic on the operand.
    function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] x,
                                          input logic [3:0] c);
        logic [15:0] r;
        case (op)
            2'b00:   r = (x << c) | (x >> (5'd16 - {1'b0, c}));
            2'b01:   r = x << c;
            2'b10:   r = (x >> c) | (x << (5'd16 - {1'b0, c}));
            default: r = $unsigned($signed(x) >>> c);
        endcase
        return r;
    endfunction

    function automatic int exp_n(input int d, input logic [1:0] op, input logic [3:0] c);
        int eff, n;
        if (d == 1) return 4;
        eff = op[1] ? ((16 - int'(c)) % 16) : int'(c);
        n = $clog2(eff + 1);
        return (n < 1) ? 1 : n;
    endfunction

    task automatic wait_idle(input int d);
        int t = 0;
        #1;
        while (!in_ready[d] && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready[d]) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input int d, input logic [1:0] op, input logic [15:0] x,
                          input logic [3:0] c, input int hold, input bit pend);
        logic [15:0] exp_v, held, px;
        logic [3:0]  pc;
        logic [1:0]  pop;
        int          n, lat;
        exp_v = model(op, x, c);
        n     = exp_n(d, op, c);
        wait_idle(d);
        @(negedge clk);
        in_valid[d] = 1'b1; in_data[d] = x; in_cnt[d] = c; in_op[d] = op;
        @(posedge clk); #1;
        pop = 2'($urandom); px = 16'($urandom); pc = 4'($urandom);
        in_valid[d] = pend; in_data[d] = px; in_cnt[d] = pc; in_op[d] = pop;
        chk("busy_after_accept", 32'(busy[d]), 32'd1);
        chk("in_ready_after_accept", 32'(in_ready[d]), 32'd0);
        lat = 1;
        while (!out_valid[d] && lat <= 8) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", 32'(lat), 32'(n + 1));
        chk("result", 32'(out_data[d]), 32'(exp_v));
        held = out_data[d];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid[d]), 32'd1);
            chk("hold_data", 32'(out_data[d]), 32'(held));
            chk("hold_in_ready", 32'(in_ready[d]), 32'd0);
        end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        chk("valid_cleared", 32'(out_valid[d]), 32'd0);
        chk("in_ready_back", 32'(in_ready[d]), 32'd1);
        if (pend) begin
            @(posedge clk); #1;
            in_valid[d] = 1'b0;
            chk("pend_accept", 32'(busy[d]), 32'd1);
            exp_v = model(pop, px, pc);
            lat = 0;
            while (!out_valid[d] && lat <= 8) begin
                @(posedge clk); #1; lat++;
            end
            chk("pend_result", 32'(out_data[d]), 32'(exp_v));
            out_ready[d] = 1'b1;
            @(posedge clk); #1;
            out_ready[d] = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = '0; in_data = '0; in_cnt = '0; in_op = '0; out_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", 32'(in_ready[d]), 32'd1);
            chk("rst_busy", 32'(busy[d]), 32'd0);
            chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
            chk("rst_out_data", 32'(out_data[d]), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;

        run_op(0, 2'b00, 16'h8001, 4'd1, 0, 1'b0);
        run_op(0, 2'b01, 16'hF00F, 4'd4, 0, 1'b0);
        run_op(0, 2'b00, 16'hF00F, 4'd4, 0, 1'b0);
        run_op(0, 2'b10, 16'h0001, 4'd1, 0, 1'b0);
        run_op(0, 2'b11, 16'h8000, 4'd3, 0, 1'b0);
        run_op(0, 2'b11, 16'h4000, 4'd15, 0, 1'b0);
        run_op(0, 2'b11, 16'hFFFE, 4'd15, 0, 1'b0);
        run_op(0, 2'b10, 16'h1234, 4'd8, 0, 1'b0);
        for (int d = 0; d < 2; d++)
            for (int op = 0; op < 4; op++)
                run_op(d, 2'(op), 16'hA5C3, 4'd0, 0, 1'b0);

        run_op(0, 2'b10, 16'hBEEF, 4'd5, 6, 1'b1);
        run_op(1, 2'b11, 16'h9000, 4'd2, 6, 1'b1);

        // Reset during ROT stage k=1 of ROR 0x1234 by 5 (eff=11).
        wait_idle(0);
        @(negedge clk);
        in_valid[0] = 1'b1; in_data[0] = 16'h1234; in_cnt[0] = 4'd5; in_op[0] = 2'b10;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy[0]), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("mid_rst_out_data", 32'(out_data[0]), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_result_after_rst", 32'(out_valid[0]), 32'd0);
        end
        run_op(0, 2'b00, 16'h1234, 4'd4, 0, 1'b0);

        for (int i = 0; i < 40; i++)
            run_op(int'($urandom_range(1, 0)), 2'($urandom), 16'($urandom), 4'($urandom),
                   int'($urandom_range(3, 0)), 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift/rotate unit for the 16-bit datapath. It executes ROL, SLL, ROR and SRA by driving a single rotate-left-by-power-of-two stage once per cycle, in place of a 4-stage combinational barrel rotator. This trades latency for area. It sits beside the ALU in execute, with a valid/ready request port from decode and a valid/ready result port to writeback.

## Interface
- EARLY_EXIT, default 1: when 1, sequencing stops after the highest set bit of the effective count. When 0, all four stages always run.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request; 1 exactly when state is IDLE.
- in_data  input  16  operand.
- in_cnt  input  4  shift/rotate amount, 0..15.
- in_op  input  2  operation: 00 ROL, 01 SLL, 10 ROR, 11 SRA.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_data  output  16  result.
- busy  output  1  1 in ROT or OUT state.

## Operation
- **States:** IDLE, ROT, OUT.
- **Accept:** in_valid & in_ready in IDLE.
  - Latch in_data into acc, and latch op, cnt, and sign = in_data[15].
  - Compute eff: for ROL/SLL, eff = in_cnt; for ROR/SRA, eff = (16 - in_cnt) mod 16.
  - Set k = 0 and go to ROT.
- **ROT, stage k (0..3):** each cycle, if eff[k] = 1 then acc <= acc rotated left by 2^k, else acc is unchanged.
- **Last stage:**
  - EARLY_EXIT=0: the last stage is k = 3.
  - EARLY_EXIT=1: the last stage is k = index of the highest set bit of eff; if eff = 0, the last stage is k = 0.
  - On the last stage, apply the mask to the rotated value, load it into out_data, set out_valid and go to OUT. Otherwise k <= k+1.
- **Mask:**
  - ROL, ROR: none.
  - SLL: bits [cnt-1:0] forced to 0.
  - SRA: bits [15:16-cnt] forced to the latched sign.
  - cnt = 0: no bits masked for any op.
- **OUT:** out_data and out_valid are held stable until out_ready = 1. On out_valid & out_ready, clear out_valid and go to IDLE.
- **No bypass:** a new request is never accepted in the cycle a result is consumed.
- **Input tolerance:** inputs are ignored outside IDLE, and in_data/in_cnt/in_op may change freely after accept.
- **Reset (rst_n low, at any time, including mid-operation):**
  - state IDLE, out_valid 0, out_data 0x0000, acc 0, k 0, busy 0, in_ready 1.
  - Any in-flight operation is dropped and no result is produced.

## Timing
- Accept at edge T, i.e. the request is sampled in cycle T.
- ROT occupies cycles T+1 .. T+n:
  - EARLY_EXIT=0: n = 4.
  - EARLY_EXIT=1: n = max(1, msb_index(eff)+1).
- out_valid rises in cycle T+n+1. Request-to-result latency is n+1 cycles, i.e. 2..5.
- With out_ready held 1, the result is consumed in cycle T+n+1 and in_ready = 1 in cycle T+n+2. Throughput is one operation per n+2 cycles.
- ROR/SRA with cnt 1..7 give eff 9..15, so n = 4. cnt 8 gives eff 8, so n = 4. cnt 0 gives eff 0, so n = 1.
- in_ready, busy and out_valid are pure functions of registered state, with no combinational path from in_valid or out_ready.

## Test plan
- **ROL, minimum latency.** ROL 0x8001, cnt 1, EARLY_EXIT=1, out_ready=1 → out_data 0x0003, out_valid exactly 2 cycles after accept, in_ready back 1 cycle later.
- **SLL masking.** SLL 0xF00F, cnt 4 → 0x00F0 after 4 cycles (n=3). ROL 0xF00F, cnt 4 → 0x00FF.
- **ROR/SRA.**
  - ROR 0x0001, cnt 1 → 0x8000, n = 4.
  - SRA 0x8000, cnt 3 → 0xF000.
  - SRA 0x4000, cnt 15 → 0x0000.
  - SRA 0xFFFE, cnt 15 → 0xFFFF.
- **Zero count and EARLY_EXIT=0.** All four ops with cnt 0 on 0xA5C3 → 0xA5C3 with n = 1. Repeat with EARLY_EXIT=0 → identical data, every latency exactly 5.
- **Backpressure and input changes.** Hold out_ready 0 for 6 cycles → out_data/out_valid stable, in_ready 0. A pending in_valid is not accepted until the cycle after the out handshake. Changing in_data after accept does not affect the result.
- **Reset mid-operation.** Pulse rst_n low during ROT stage k=1 of ROR 0x1234 cnt 5 → outputs take their reset values immediately, with no out_valid afterwards. A subsequent ROL 0x1234 cnt 4 → 0x2341.
